demux_dispatch: RTL and testbench
=================================

DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter DEPTH, default 2, entries per output channel buffer (power of two, >=2).
REQ-003 iClk  input  1  single clock; all state updates on rising edge.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iD  input  WIDTH  write data word to be routed.
REQ-006 iS1  input  1  channel select, MSB.
REQ-007 iS0  input  1  channel select, LSB.
REQ-008 iValid  input  1  iD/iS1/iS0 valid this cycle.
REQ-009 oReady  output  1  dispatcher can accept the presented word this cycle.
REQ-010 oZ0, oZ1, oZ2, oZ3  output  WIDTH each  head word of channel 0..3.
REQ-011 oValid  output  4  bit k = channel k holds at least one word.
REQ-012 iReady  input  4  bit k = consumer k takes the head word this cycle.
REQ-013 oCount  output  16  total words accepted since reset.

Function
REQ-014 Selected channel k = {iS1,iS0}: 00->0, 01->1, 10->2, 11->3.
REQ-015 oReady SHALL be 1 iff channel k holds fewer than DEPTH words; it SHALL depend only on select and registered occupancy, never on iReady.
REQ-016 A word is accepted on a rising edge where iValid && oReady; it is appended to channel k's FIFO.
REQ-017 Channel k pops its head on a rising edge where oValid[k] && iReady[k]; iReady[k] while oValid[k]=0 has no effect.
REQ-018 Latency: word accepted at edge N into an empty channel appears on oZk with oValid[k]=1 from edge N onward (one-cycle registered latency, first-word fall-through).
REQ-019 Per-channel order preserved; no ordering guarantee across channels.
REQ-020 oZk SHALL drive all-zero whenever oValid[k]=0.
REQ-021 Full channel: push refused (oReady=0) even if the same channel pops in that cycle; no pass-through.
REQ-022 Simultaneous push and pop on the same non-full, non-empty channel: occupancy unchanged, new word queued behind remaining entries.
REQ-023 Simultaneous push and pop on an empty channel is impossible (pop requires oValid); push only.
REQ-024 Pops on other channels proceed in the same cycle as a push, independently.
REQ-025 oCount increments by 1 per accepted word, wraps 0xFFFF->0x0000, unaffected by pops.
REQ-026 iValid=0 with oReady=1 accepts nothing; oReady is still driven from select.

Reset
REQ-027 While iRst=1 at a rising edge: all channel occupancies 0, read/write pointers 0, oValid=4'b0000, oZ0..oZ3=0, oCount=0.
REQ-028 Reset mid-operation discards all buffered words; no accept or pop occurs on a reset edge regardless of iValid/iReady.
REQ-029 First accept possible on the first rising edge with iRst=0.

Structure
REQ-030 Shared package holds: WIDTH default, DEPTH default, channel count 4, oCount width 16, select encoding constants CH0..CH3.
REQ-031 One sub-module demux_chan_fifo (DEPTH-entry FWFT FIFO with push, pop, full, empty, head) instantiated four times; top holds select decode, oReady mux, and oCount.

Verification
REQ-032 Reset, then push 0x11111111 sel=10 -> next cycle oValid=0100, oZ2=0x11111111, oZ0/1/3=0, oCount=1.
REQ-033 iReady=0000, push 0xA, 0xB, 0xC to sel=00 on consecutive cycles -> 0xA,0xB accepted, oReady=0 on third, oValid[0]=1, oCount=2; then iReady[0]=1 for 2 cycles -> oZ0 shows 0xA then 0xB, oValid[0] drops.
REQ-034 Channel 1 full with iReady[1]=1 and push to sel=01 -> push refused that cycle, one pop occurs, next cycle oReady=1 for sel=01.
REQ-035 Channel 3 holds one word, same cycle push 0x5 sel=11 and iReady[3]=1 -> occupancy stays 1, oZ3=0x5 next cycle.
REQ-036 Load channels 0 and 2, assert iRst for one cycle with iValid=1, iReady=1111 -> oValid=0000, oZ all 0, oCount=0, no word accepted.
REQ-037 Preload oCount to 0xFFFF via 65535 accepts with continuous pops, one more accept -> oCount=0x0000.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// demux_dispatch_pkg: shared constants for the four-channel dispatcher
package demux_dispatch_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;
  localparam int NCH = 4;
  localparam int CNT_W = 16;
  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;
endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: DEPTH-entry first-word-fall-through FIFO, head forced to zero when empty
module demux_chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_head = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/demux_dispatch.sv
// demux_dispatch: routes each accepted word to one of four FWFT channel FIFOs
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iD,
  input  logic             iS1,
  input  logic             iS0,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oZ0,
  output logic [WIDTH-1:0] oZ1,
  output logic [WIDTH-1:0] oZ2,
  output logic [WIDTH-1:0] oZ3,
  output logic [NCH-1:0]   oValid,
  input  logic [NCH-1:0]   iReady,
  output logic [CNT_W-1:0] oCount
);
  logic [1:0] w_sel;
  logic [NCH-1:0] w_full, w_empty;
  logic [WIDTH-1:0] w_head [NCH];
  logic w_acc;
  logic [CNT_W-1:0] r_count;
  assign w_sel = {iS1, iS0};
  // readiness comes only from registered occupancy, so a same-cycle pop never unblocks a full channel
  assign oReady = !w_full[w_sel];
  assign w_acc = iValid && oReady;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .i_clk  (iClk),
      .i_rst  (iRst),
      .i_push (w_acc && w_sel == 2'(c)),
      .i_din  (iD),
      .i_pop  (iReady[c]),
      .o_full (w_full[c]),
      .o_empty(w_empty[c]),
      .o_head (w_head[c])
    );
  end
  assign oValid = ~w_empty;
  assign oZ0 = w_head[CH0];
  assign oZ1 = w_head[CH1];
  assign oZ2 = w_head[CH2];
  assign oZ3 = w_head[CH3];
  always_ff @(posedge iClk) begin
    if (iRst) r_count <= '0;
    else if (w_acc) r_count <= r_count + CNT_W'(1);
  end
  assign oCount = r_count;
endmodule

// File: tb/tb_demux_dispatch.sv
// tb_demux_dispatch: directed vector table plus a counter-wrap sequence for demux_dispatch
module tb_demux_dispatch;
  logic iClk = 1'b0;
  logic iRst;
  logic [31:0] iD;
  logic iS1, iS0, iValid, oReady;
  logic [31:0] oZ0, oZ1, oZ2, oZ3;
  logic [3:0] oValid, iReady;
  logic [15:0] oCount;
  logic [31:0] oz [4];
  int n_vec = 0;
  int n_err = 0;

  demux_dispatch dut (
    .iClk(iClk), .iRst(iRst), .iD(iD), .iS1(iS1), .iS0(iS0), .iValid(iValid),
    .oReady(oReady), .oZ0(oZ0), .oZ1(oZ1), .oZ2(oZ2), .oZ3(oZ3),
    .oValid(oValid), .iReady(iReady), .oCount(oCount)
  );

  always #5 iClk = ~iClk;
  assign oz[0] = oZ0;
  assign oz[1] = oZ1;
  assign oz[2] = oZ2;
  assign oz[3] = oZ3;

  typedef struct {
    logic rst;
    logic [31:0] d;
    logic [1:0] s;
    logic v;
    logic [3:0] rdy;
    logic e_rdy;
    logic [3:0] e_val;
    logic [3:0][31:0] e_z;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic rst, logic [31:0] d, logic [1:0] s, logic v, logic [3:0] rdy,
                              logic e_rdy, logic [3:0] e_val, logic [31:0] z3, logic [31:0] z2,
                              logic [31:0] z1, logic [31:0] z0, logic [15:0] e_cnt);
    vec_t t;
    t.rst = rst; t.d = d; t.s = s; t.v = v; t.rdy = rdy;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_z = {z3, z2, z1, z0}; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [31:0] d, logic [1:0] s, logic v, logic [3:0] rdy);
    iRst = rst; iD = d; {iS1, iS0} = s; iValid = v; iReady = rdy;
  endtask

  initial begin
    // push to ch2; ch0 fills and refuses a third word, then drains
    tbl[0]  = mk(0, 32'h11111111, 2, 1, 4'b0000, 1, 4'b0100, 0, 32'h11111111, 0, 0, 1);
    tbl[1]  = mk(0, 32'hA, 0, 1, 4'b0000, 1, 4'b0101, 0, 32'h11111111, 0, 32'hA, 2);
    tbl[2]  = mk(0, 32'hB, 0, 1, 4'b0000, 1, 4'b0101, 0, 32'h11111111, 0, 32'hA, 3);
    tbl[3]  = mk(0, 32'hC, 0, 1, 4'b0000, 0, 4'b0101, 0, 32'h11111111, 0, 32'hA, 3);
    tbl[4]  = mk(0, 32'h0, 0, 0, 4'b0001, 0, 4'b0101, 0, 32'h11111111, 0, 32'hB, 3);
    tbl[5]  = mk(0, 32'h0, 0, 0, 4'b0001, 1, 4'b0100, 0, 32'h11111111, 0, 0, 3);
    tbl[6]  = mk(0, 32'h0, 2, 0, 4'b0001, 1, 4'b0100, 0, 32'h11111111, 0, 0, 3);
    // full ch1 with pop: push refused, pop happens
    tbl[7]  = mk(0, 32'h21, 1, 1, 4'b0000, 1, 4'b0110, 0, 32'h11111111, 32'h21, 0, 4);
    tbl[8]  = mk(0, 32'h22, 1, 1, 4'b0000, 1, 4'b0110, 0, 32'h11111111, 32'h21, 0, 5);
    tbl[9]  = mk(0, 32'h23, 1, 1, 4'b0010, 0, 4'b0110, 0, 32'h11111111, 32'h22, 0, 5);
    tbl[10] = mk(0, 32'h0, 1, 0, 4'b0000, 1, 4'b0110, 0, 32'h11111111, 32'h22, 0, 5);
    // ch3 with one word: push+pop keeps occupancy 1
    tbl[11] = mk(0, 32'h31, 3, 1, 4'b0000, 1, 4'b1110, 32'h31, 32'h11111111, 32'h22, 0, 6);
    tbl[12] = mk(0, 32'h5, 3, 1, 4'b1000, 1, 4'b1110, 32'h5, 32'h11111111, 32'h22, 0, 7);
    tbl[13] = mk(0, 32'h0, 3, 0, 4'b1000, 1, 4'b0110, 0, 32'h11111111, 32'h22, 0, 7);
    // push ch2 while ch1 pops; then full ch2 refuses push despite its own pop
    tbl[14] = mk(0, 32'h12, 2, 1, 4'b0010, 1, 4'b0100, 0, 32'h11111111, 0, 0, 8);
    tbl[15] = mk(0, 32'h13, 2, 1, 4'b0100, 0, 4'b0100, 0, 32'h12, 0, 0, 8);
    // reset with valid/ready active discards everything
    tbl[16] = mk(0, 32'h41, 0, 1, 4'b0000, 1, 4'b0101, 0, 32'h12, 0, 32'h41, 9);
    tbl[17] = mk(1, 32'h99, 0, 1, 4'b1111, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 32'h77, 1, 1, 4'b0000, 1, 4'b0010, 0, 0, 32'h77, 0, 1);

    drive(1, 0, 0, 0, 4'b0000);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    #1;
    chk("reset oValid", 32'(oValid), 0);
    chk("reset oCount", 32'(oCount), 0);
    chk("reset oReady", 32'(oReady), 1);
    for (int k = 0; k < 4; k++) chk($sformatf("reset oZ%0d", k), oz[k], 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge iClk);
      drive(tbl[i].rst, tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d oReady", i), 32'(oReady), 32'(tbl[i].e_rdy));
      @(posedge iClk);
      #1;
      chk($sformatf("v%0d oValid", i), 32'(oValid), 32'(tbl[i].e_val));
      chk($sformatf("v%0d oCount", i), 32'(oCount), 32'(tbl[i].e_cnt));
      for (int k = 0; k < 4; k++) chk($sformatf("v%0d oZ%0d", i, k), oz[k], tbl[i].e_z[k]);
    end

    // counter wrap: stream into ch0 while it pops every cycle (count is 1 here)
    for (int n = 2; n <= 65535; n++) begin
      @(negedge iClk);
      drive(0, 32'(n), 0, 1, 4'b0001);
    end
    @(negedge iClk);
    drive(0, 0, 0, 0, 4'b0000);
    #1;
    chk("wrap pre oCount", 32'(oCount), 32'hFFFF);
    chk("wrap pre oZ0", oZ0, 32'd65535);
    chk("wrap pre oReady", 32'(oReady), 1);
    @(negedge iClk);
    drive(0, 32'hCAFE, 0, 1, 4'b0001);
    @(posedge iClk);
    #1;
    chk("wrap oCount", 32'(oCount), 0);
    chk("wrap oZ0", oZ0, 32'hCAFE);
    chk("wrap oZ1", oZ1, 32'h77);
    chk("wrap oValid", 32'(oValid), 32'b0011);
    drive(0, 0, 0, 0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
